// File: rtl/decod_sched_pkg.sv
// Shared types, sizes and the round-robin pick function for the decoder scheduler.
package decod_sched_pkg;

    localparam int NUM_REQ = 16;
    localparam int IDX_W   = 4;
    localparam int HOLD_W  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // First set request scanning ptr, ptr+1, ... with 4-bit wraparound.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr
    );
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/decod4to16.sv
// 4-to-16 one-hot decoder with enable; all outputs low when disabled.
module decod4to16
    import decod_sched_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    input  logic               en,
    output logic [NUM_REQ-1:0] onehot
);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_line
            assign onehot[gi] = en && (idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/decod_rr_sched.sv
// Round-robin owner of a shared 4-to-16 decoder: grants one requester at a time
// with a two-cycle dead gap between grants and an optional hold timeout.
module decod_rr_sched
    import decod_sched_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic               clk_pad,
    input  logic               rst_pad,
    input  logic [NUM_REQ-1:0] req_pad,
    input  logic               done_pad,
    output logic [IDX_W-1:0]   idx_pad,
    output logic               en_pad,
    output logic [NUM_REQ-1:0] gnt_pad,
    output logic               busy_pad,
    output logic               timeout_pad
);

    localparam bit               HOLD_LIMITED = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [IDX_W-1:0]  ptr_reg, ptr_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic              en_reg, en_next;
    logic              busy_reg, busy_next;
    logic              timeout_reg, timeout_next;

    always_ff @(posedge clk_pad or posedge rst_pad) begin
        if (rst_pad) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            ptr_reg      <= '0;
            hold_cnt_reg <= '0;
            en_reg       <= 1'b0;
            busy_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            ptr_reg      <= ptr_next;
            hold_cnt_reg <= hold_cnt_next;
            en_reg       <= en_next;
            busy_reg     <= busy_next;
            timeout_reg  <= timeout_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        ptr_next      = ptr_reg;
        hold_cnt_next = hold_cnt_reg;
        timeout_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req_pad) begin
                    idx_next      = rr_pick(req_pad, ptr_reg);
                    hold_cnt_next = '0;
                    state_next    = GRANT;
                end
            end
            GRANT: begin
                // An explicit finish beats the hold limit in the same cycle.
                if (done_pad || !req_pad[idx_reg]) begin
                    state_next = RELEASE;
                end else if (HOLD_LIMITED && (hold_cnt_reg == HOLD_LAST)) begin
                    state_next   = RELEASE;
                    timeout_next = 1'b1;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            RELEASE: begin
                ptr_next   = idx_reg + 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        en_next   = (state_next == GRANT);
        busy_next = (state_next != IDLE);
    end

    decod4to16 u_dec (
        .idx    (idx_reg),
        .en     (en_reg),
        .onehot (gnt_pad)
    );

    assign idx_pad     = idx_reg;
    assign en_pad      = en_reg;
    assign busy_pad    = busy_reg;
    assign timeout_pad = timeout_reg;

endmodule

// File: tb/tb_decod_rr_sched.sv
// Scoreboard bench for decod_rr_sched: four instances with different hold limits,
// one selected at a time; a grant monitor pops expected grants as they complete.
module tb_decod_rr_sched;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic [1:0]  sel;

    logic [15:0] req_a  [4];
    logic        done_a [4];
    logic [3:0]  idx_a  [4];
    logic        en_a   [4];
    logic [15:0] gnt_a  [4];
    logic        busy_a [4];
    logic        to_a   [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dut
            assign req_a[gi]  = (sel == 2'(gi)) ? req : 16'h0;
            assign done_a[gi] = (sel == 2'(gi)) ? done : 1'b0;
            decod_rr_sched #(
                .MAX_HOLD (gi == 0 ? 15 : gi == 1 ? 4 : gi == 2 ? 2 : 0)
            ) u_dut (
                .clk_pad     (clk),
                .rst_pad     (rst),
                .req_pad     (req_a[gi]),
                .done_pad    (done_a[gi]),
                .idx_pad     (idx_a[gi]),
                .en_pad      (en_a[gi]),
                .gnt_pad     (gnt_a[gi]),
                .busy_pad    (busy_a[gi]),
                .timeout_pad (to_a[gi])
            );
        end
    endgenerate

    logic [3:0]  idx_s;
    logic        en_s;
    logic [15:0] gnt_s;
    logic        busy_s;
    logic        to_s;
    assign idx_s  = idx_a[sel];
    assign en_s   = en_a[sel];
    assign gnt_s  = gnt_a[sel];
    assign busy_s = busy_a[sel];
    assign to_s   = to_a[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Expected grant: index, cycles with en high, timeout pulse, en-low gap before it (0 = any).
    typedef struct {
        int idx;
        int len;
        int to;
        int gap;
    } exp_t;
    exp_t sb_q[$];

    task automatic push_exp(input int i, input int l, input int t, input int g);
        exp_t e;
        e.idx = i; e.len = l; e.to = t; e.gap = g;
        sb_q.push_back(e);
    endtask

    logic en_prev   = 1'b0;
    logic have_prev = 1'b0;
    int   cur_idx   = 0;
    int   cur_len   = 0;
    int   cur_gap   = 0;
    int   gap_cnt   = 0;

    always @(negedge clk) begin
        if (rst) begin
            en_prev   = 1'b0;
            have_prev = 1'b0;
            gap_cnt   = 0;
        end else begin
            check_val("gnt_decode", gnt_s, en_s ? (32'h1 << idx_s) : 32'h0);
            if (to_s && !(en_prev && !en_s)) check_val("timeout_stray", to_s, 0);
            if (en_s && !en_prev) begin
                cur_idx = int'(idx_s);
                cur_len = 1;
                cur_gap = have_prev ? gap_cnt : 0;
            end else if (en_s) begin
                cur_len++;
            end else if (en_prev) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("grant idx=%0d len=%0d timeout=%0d gap=%0d", cur_idx, cur_len, to_s, cur_gap);
                    check_val("grant_idx", cur_idx, e.idx);
                    check_val("grant_len", cur_len, e.len);
                    check_val("grant_timeout", to_s, e.to);
                    check_val("release_busy", busy_s, 1);
                    if (e.gap != 0) check_val("grant_gap", cur_gap, e.gap);
                end
                have_prev = 1'b1;
                gap_cnt   = 1;
            end else if (have_prev) begin
                gap_cnt++;
            end
            en_prev = en_s;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en(input logic val, input string tag);
        int n;
        n = 0;
        while (en_s !== val && n < 100) begin
            tick();
            n++;
        end
        check_val(tag, en_s, val);
    endtask

    task automatic do_reset(input logic [1:0] s);
        rst  = 1'b1;
        req  = 16'h0;
        done = 1'b0;
        sel  = s;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic finish_scn(input string tag);
        req  = 16'h0;
        done = 1'b0;
        repeat (4) tick();
        check_val(tag, sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        req  = 16'h0;
        done = 1'b0;
        sel  = 2'd0;
        repeat (3) tick();
        check_val("rst_idx", idx_s, 0);
        check_val("rst_en", en_s, 0);
        check_val("rst_gnt", gnt_s, 0);
        check_val("rst_busy", busy_s, 0);
        check_val("rst_timeout", to_s, 0);

        // Single requester, done on 3rd grant cycle, then regrant after two dead cycles
        do_reset(2'd0);
        push_exp(0, 3, 0, 0);
        push_exp(0, 1, 0, 2);
        req = 16'h0001;
        wait_en(1'b1, "s1_wait");
        check_val("s1_gnt", gnt_s, 16'h0001);
        check_val("s1_busy", busy_s, 1);
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        wait_en(1'b1, "s1_regrant");
        done = 1'b1;
        tick();
        done = 1'b0;
        finish_scn("s1_leftover");

        // Fairness between requesters 0 and 15
        do_reset(2'd0);
        for (int k = 0; k < 6; k++) push_exp((k % 2) ? 15 : 0, 1, 0, (k == 0) ? 0 : 2);
        req = 16'h8001;
        for (int k = 0; k < 6; k++) begin
            wait_en(1'b1, "s2_wait");
            done = 1'b1;
            tick();
            done = 1'b0;
        end
        finish_scn("s2_leftover");

        // Pointer wrap after a grant to 15
        do_reset(2'd0);
        push_exp(15, 1, 0, 0);
        for (int k = 0; k < 5; k++) push_exp(k, 1, 0, 2);
        req = 16'h8000;
        wait_en(1'b1, "s3_wait15");
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 16'hFFFF;
        for (int k = 0; k < 5; k++) begin
            wait_en(1'b1, "s3_wait");
            done = 1'b1;
            tick();
            done = 1'b0;
        end
        finish_scn("s3_leftover");

        // Hold timeout with MAX_HOLD=4
        do_reset(2'd1);
        push_exp(4, 4, 1, 0);
        push_exp(4, 4, 1, 2);
        req = 16'h0010;
        wait_en(1'b1, "s4_wait1");
        wait_en(1'b0, "s4_rel1");
        check_val("s4_to1", to_s, 1);
        wait_en(1'b1, "s4_wait2");
        wait_en(1'b0, "s4_rel2");
        check_val("s4_to2", to_s, 1);
        finish_scn("s4_leftover");

        // Request withdrawal on grant cycle 2
        do_reset(2'd0);
        push_exp(7, 2, 0, 0);
        req = 16'h0080;
        wait_en(1'b1, "s5_wait");
        tick();
        req = 16'h0;
        tick();
        check_val("s5_to", to_s, 0);
        finish_scn("s5_leftover");

        // Done and hold limit together with MAX_HOLD=2
        do_reset(2'd2);
        push_exp(2, 2, 0, 0);
        req = 16'h0004;
        wait_en(1'b1, "s6_wait");
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 16'h0;
        check_val("s6_to", to_s, 0);
        finish_scn("s6_leftover");

        // Unbounded hold with MAX_HOLD=0
        do_reset(2'd3);
        push_exp(9, 20, 0, 0);
        req = 16'h0200;
        wait_en(1'b1, "s7_wait");
        repeat (19) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 16'h0;
        finish_scn("s7_leftover");

        // Asynchronous reset in the middle of a grant to 5
        do_reset(2'd0);
        req = 16'h0020;
        wait_en(1'b1, "s8_wait");
        tick();
        check_val("s8_gnt_pre", gnt_s, 16'h0020);
        #2;
        rst = 1'b1;
        #1;
        check_val("s8_gnt_async", gnt_s, 0);
        check_val("s8_en_async", en_s, 0);
        check_val("s8_busy_async", busy_s, 0);
        req = 16'h0;
        tick();
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check_val("s8_idx", idx_s, 0);
        check_val("s8_en", en_s, 0);
        check_val("s8_gnt", gnt_s, 0);
        check_val("s8_busy", busy_s, 0);
        check_val("s8_timeout", to_s, 0);
        check_val("s8_leftover", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
